dcache: RTL

Direct-mapped, write-back, write-allocate data cache between the MEM stage and the memory controller. It serves word loads and stores from the pipeline, produces `dhit`, which the hazard unit uses to stall EX/MEM on a miss, and runs a miss/write-back state machine against a single-port RAM interface. On `halt` it writes every dirty line back to RAM and then raises `flushed`.

---
 rtl/cache_pkg.sv | 13 +
 rtl/dcache_if.sv | 15 +
 rtl/dcache.sv | 99 +++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared dcache types, line layout and default geometry.
package cache_pkg;
  localparam int DC_SETS = 16;
  localparam int DC_WORD_W = 32;
  localparam int DC_TAG_W = DC_WORD_W - 2;
  typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, HALTED} dcache_state_t;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [DC_TAG_W-1:0] tag;
    logic [DC_WORD_W-1:0] data;
  } dline_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: pipeline-side and RAM-side signals of the data cache.
interface dcache_if #(parameter int WORD_W = 32);
  logic dmemREN, dmemWEN, dhit, halt, flushed;
  logic [WORD_W-1:0] dmemaddr, dmemstore, dmemload;
  logic ramREN, ramWEN, ramwait;
  logic [WORD_W-1:0] ramaddr, ramstore, ramload;
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramwait,
    input dmemload, dhit, flushed, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    input dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramwait,
    output dmemload, dhit, flushed, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate data cache with halt-time flush.
module dcache
  import cache_pkg::*;
#(
  parameter int SETS = DC_SETS,
  parameter int WORD_W = DC_WORD_W
) (
  input logic CLK,
  input logic RST,
  dcache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  dcache_state_t r_state, w_next;
  dline_t r_lines [SETS];
  logic [IDX_W:0] r_idx;
  logic [IDX_W-1:0] w_idx, w_fidx;
  logic [DC_TAG_W-1:0] w_tag;
  dline_t w_line, w_fline;
  logic w_req, w_hit, w_dhit, w_ren, w_wen, w_flushed;
  logic w_store, w_fill, w_adv, w_fdirty;
  logic [WORD_W-1:0] w_raddr, w_rstore, w_vaddr, w_faddr;
  assign w_idx = bus.dmemaddr[IDX_W+1:2];
  assign w_tag = DC_TAG_W'(bus.dmemaddr >> (IDX_W + 2));
  assign w_line = r_lines[w_idx];
  assign w_fidx = r_idx[IDX_W-1:0];
  assign w_fline = r_lines[w_fidx];
  assign w_req = bus.dmemREN | bus.dmemWEN;
  assign w_hit = w_line.valid && (w_line.tag == w_tag);
  assign w_vaddr = WORD_W'({w_line.tag, w_idx, 2'b00});
  assign w_faddr = WORD_W'({w_fline.tag, w_fidx, 2'b00});
  assign w_fdirty = w_fline.valid & w_fline.dirty;
  always_comb begin
    w_next = r_state;
    w_dhit = 1'b0;
    w_ren = 1'b0;
    w_wen = 1'b0;
    w_raddr = '0;
    w_rstore = '0;
    w_flushed = 1'b0;
    w_store = 1'b0;
    w_fill = 1'b0;
    w_adv = 1'b0;
    case (r_state)
      IDLE: begin
        w_dhit = w_req & w_hit;
        w_store = w_dhit & bus.dmemWEN;
        if (w_req && !w_hit) w_next = (w_line.valid && w_line.dirty) ? WB : ALLOC;
        else if (bus.halt) w_next = FLUSH;
      end
      WB: begin
        w_wen = 1'b1;
        w_raddr = w_vaddr;
        w_rstore = w_line.data;
        w_next = bus.ramwait ? WB : ALLOC;
      end
      ALLOC: begin
        w_ren = 1'b1;
        w_raddr = bus.dmemaddr & ~WORD_W'(3);
        w_fill = ~bus.ramwait;
        w_next = bus.ramwait ? ALLOC : IDLE;
      end
      FLUSH: begin
        w_wen = w_fdirty;
        w_raddr = w_fdirty ? w_faddr : '0;
        w_rstore = w_fdirty ? w_fline.data : '0;
        w_adv = ~w_fdirty | ~bus.ramwait;
        if (w_adv && r_idx == (IDX_W+1)'(SETS - 1)) w_next = HALTED;
      end
      HALTED: w_flushed = 1'b1;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_lines <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_store) begin
        r_lines[w_idx].data <= bus.dmemstore;
        r_lines[w_idx].dirty <= 1'b1;
      end
      if (w_fill) r_lines[w_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: w_tag, data: bus.ramload};
      if (r_state == IDLE && w_next == FLUSH) r_idx <= '0;
      if (w_adv) begin
        r_idx <= r_idx + 1'b1;
        if (w_fdirty) r_lines[w_fidx].dirty <= 1'b0;
      end
    end
  end
  assign bus.dmemload = w_line.data;
  assign bus.dhit = w_dhit;
  assign bus.flushed = w_flushed;
  assign bus.ramREN = w_ren;
  assign bus.ramWEN = w_wen;
  assign bus.ramaddr = w_raddr;
  assign bus.ramstore = w_rstore;
endmodule
